// File: rtl/button_conditioner_pkg.sv
// Shared types and sizing helpers for the button/switch conditioner.
package button_conditioner_pkg;

    localparam int NUM_BTN = 3;
    localparam int NUM_SW  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } btn_state_e;

    // Counter width large enough that none of the timing limits can wrap it.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Board-side signal bundle: raw inputs in, conditioned levels and strobes out.
interface button_conditioner_if;
    import button_conditioner_pkg::*;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_SW-1:0]  sw_raw;
    logic [NUM_BTN-1:0] button_export;
    logic [NUM_SW-1:0]  switch_export;
    logic [NUM_BTN-1:0] press_pulse;
    logic [NUM_BTN-1:0] hold;

    modport master (
        output btn_raw, sw_raw,
        input  button_export, switch_export, press_pulse, hold
    );

    modport slave (
        input  btn_raw, sw_raw,
        output button_export, switch_export, press_pulse, hold
    );
endinterface

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchronizer, optional inversion, and a
// consecutive-difference counter that flips the stable level.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o
);
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES, 1, 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [1:0]    fill_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sampled;

    // fill_q holds off counting until the synchronizer carries real samples,
    // so reset-value zeros are never mistaken for an input level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            fill_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            fill_q   <= {fill_q[0], 1'b1};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sampled = sync_q[1] ^ INVERT;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (fill_q[1] && (sampled != stable_q)) begin
            if (cnt_q >= CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = stable_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces buttons and switches; buttons additionally get press strobes,
// auto-repeat and a hold flag from a per-channel FSM.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    button_conditioner_if.slave  bus
);
    localparam int            TW          = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_SW-1:0]  sw_level;
    logic [NUM_BTN-1:0] pulse_vec;
    logic [NUM_BTN-1:0] hold_vec;

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (1'b0)
        ) u_sw (
            .clk     (clk_clk),
            .rst_n   (reset_reset_n),
            .raw_i   (bus.sw_raw[gi]),
            .level_o (sw_level[gi])
        );
    end

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_state_e    state_q, state_d;
        logic [TW-1:0] timer_q, timer_d;
        logic          pulse;

        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (1'b1)
        ) u_btn (
            .clk     (clk_clk),
            .rst_n   (reset_reset_n),
            .raw_i   (bus.btn_raw[gi]),
            .level_o (btn_level[gi])
        );

        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                state_q <= IDLE;
                timer_q <= '0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
            end
        end

        // In PRESSED the timer counts held cycles including the press cycle;
        // in REPEAT it is the phase within the repeat period (0 = pulse).
        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            pulse   = 1'b0;
            case (state_q)
                IDLE: begin
                    timer_d = '0;
                    if (btn_level[gi]) begin
                        pulse   = 1'b1;
                        state_d = PRESSED;
                        timer_d = TW'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_level[gi]) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else if (timer_q >= DELAY_LAST) begin
                        state_d = REPEAT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!btn_level[gi]) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        pulse   = (timer_q == '0);
                        timer_d = (timer_q >= PERIOD_LAST) ? '0 : timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end

        assign pulse_vec[gi] = pulse;
        assign hold_vec[gi]  = (state_q == REPEAT);
    end

    assign bus.button_export = btn_level;
    assign bus.switch_export = sw_level;
    assign bus.press_pulse   = pulse_vec;
    assign bus.hold          = hold_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: expected press strobes are queued with their cycle
// stamps when stimulus is applied and matched as the DUT emits them.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    button_conditioner_if bus();

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int at, input logic [2:0] v);
        exp_t e;
        e.cyc = at;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic sb_drain(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every strobe the DUT emits must be the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.press_pulse != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("pulse_extra", 32'(bus.press_pulse), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("pulse cycle %0d value %b (expected cycle %0d value %b)",
                         cyc, bus.press_pulse, e.cyc, e.val);
                check("pulse_cyc", 32'(cyc), 32'(e.cyc));
                check("pulse_val", 32'(bus.press_pulse), 32'(e.val));
            end
        end
    end

    initial begin
        int c;
        int r;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.btn_raw = 3'b111;
        bus.sw_raw  = 3'b000;

        wait_cyc(3);
        check("rst_button", 32'(bus.button_export), 32'd0);
        check("rst_switch", 32'(bus.switch_export), 32'd0);
        check("rst_pulse",  32'(bus.press_pulse),   32'd0);
        check("rst_hold",   32'(bus.hold),          32'd0);
        rst_n = 1'b1;
        wait_cyc(12);
        check("idle_button", 32'(bus.button_export), 32'd0);
        check("idle_hold",   32'(bus.hold),          32'd0);

        // Single press on button 0
        c = cyc;
        bus.btn_raw = 3'b110;
        push_exp(c + 6, 3'b001);
        wait_cyc(5);
        check("btn0_before", 32'(bus.button_export), 32'd0);
        wait_cyc(1);
        check("btn0_level", 32'(bus.button_export), 32'd1);
        bus.btn_raw = 3'b111;
        wait_cyc(20);
        check("btn0_released", 32'(bus.button_export), 32'd0);
        sb_drain("sb_btn0");

        // 3-cycle glitch on button 1 is rejected
        bus.btn_raw = 3'b101;
        wait_cyc(3);
        bus.btn_raw = 3'b111;
        wait_cyc(15);
        check("glitch3_level", 32'(bus.button_export), 32'd0);
        sb_drain("sb_glitch3");

        // 4-cycle low on button 1 is exactly long enough
        c = cyc;
        bus.btn_raw = 3'b101;
        push_exp(c + 6, 3'b010);
        wait_cyc(4);
        bus.btn_raw = 3'b111;
        wait_cyc(5);
        check("glitch4_level", 32'(bus.button_export), 32'd2);
        wait_cyc(1);
        check("glitch4_release", 32'(bus.button_export), 32'd0);
        wait_cyc(15);
        sb_drain("sb_glitch4");

        // Long hold on button 2: press, repeats, release
        c = cyc;
        bus.btn_raw = 3'b011;
        push_exp(c + 6, 3'b100);
        for (int k = 0; k < 6; k++) push_exp(c + 16 + 5 * k, 3'b100);
        wait_cyc(15);
        check("hold_before", 32'(bus.hold), 32'd0);
        wait_cyc(1);
        check("hold_on", 32'(bus.hold), 32'd4);
        wait_cyc(24);
        bus.btn_raw = 3'b111;
        wait_cyc(5);
        check("hold_still", 32'(bus.hold), 32'd4);
        wait_cyc(2);
        check("hold_off", 32'(bus.hold), 32'd0);
        check("hold_level_off", 32'(bus.button_export), 32'd0);
        wait_cyc(15);
        sb_drain("sb_hold");

        // All three buttons together
        c = cyc;
        bus.btn_raw = 3'b000;
        push_exp(c + 6, 3'b111);
        wait_cyc(8);
        bus.btn_raw = 3'b111;
        wait_cyc(20);
        sb_drain("sb_all3");

        // Switches: debounce only
        c = cyc;
        bus.sw_raw = 3'b101;
        wait_cyc(5);
        check("sw_before", 32'(bus.switch_export), 32'd0);
        wait_cyc(1);
        check("sw_level", 32'(bus.switch_export), 32'd5);
        check("sw_no_button", 32'(bus.button_export), 32'd0);
        bus.sw_raw = 3'b000;
        wait_cyc(5);
        check("sw_hold_level", 32'(bus.switch_export), 32'd5);
        wait_cyc(1);
        check("sw_cleared", 32'(bus.switch_export), 32'd0);
        sb_drain("sb_sw");

        // Reset during REPEAT with the button kept held
        c = cyc;
        bus.btn_raw = 3'b011;
        push_exp(c + 6, 3'b100);
        push_exp(c + 16, 3'b100);
        wait_cyc(18);
        check("rpt_hold", 32'(bus.hold), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_button", 32'(bus.button_export), 32'd0);
        check("arst_pulse",  32'(bus.press_pulse),   32'd0);
        check("arst_hold",   32'(bus.hold),          32'd0);
        sb_drain("sb_before_rst");
        wait_cyc(3);
        rst_n = 1'b1;
        r = cyc;
        push_exp(r + 6, 3'b100);
        wait_cyc(5);
        check("post_rst_before", 32'(bus.button_export), 32'd0);
        wait_cyc(1);
        check("post_rst_level", 32'(bus.button_export), 32'd4);
        bus.btn_raw = 3'b111;
        wait_cyc(20);
        sb_drain("sb_post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000, meaning held-button cycles from accepted press to first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, meaning cycles between subsequent auto-repeat pulses.
REQ-004 Port clk_clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-005 Port reset_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port btn_raw, input, 3 bits: raw board push-buttons, active-low, asynchronous to clk_clk.
REQ-007 Port sw_raw, input, 3 bits: raw board slide switches, active-high, asynchronous to clk_clk.
REQ-008 Port button_export, output, 3 bits: debounced button levels, active-high (1 = pressed), wired to the button PIO input.
REQ-009 Port switch_export, output, 3 bits: debounced switch levels, wired to the switch PIO input.
REQ-010 Port press_pulse, output, 3 bits: one-cycle strobe per accepted press and per auto-repeat event.
REQ-011 Port hold, output, 3 bits: high while a button has been held at least REPEAT_DELAY cycles.

Function
REQ-012 Each of the 6 raw inputs SHALL pass through a 2-flop synchronizer before any other logic; buttons SHALL be inverted after synchronization.
REQ-013 Each channel SHALL keep a stable level and a debounce counter; the counter increments while the synchronized level differs from the stable level and clears on any cycle where it equals it.
REQ-014 The stable level SHALL toggle, and the counter clear, on the edge where the counter would reach DEBOUNCE_CYCLES; a raw step held steady therefore appears at the output DEBOUNCE_CYCLES+2 cycles later.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change and no pulse.
REQ-016 Each button channel SHALL run a FSM: IDLE (stable 0) -> PRESSED on accepted press; PRESSED -> REPEAT after REPEAT_DELAY held cycles; REPEAT stays while held; PRESSED or REPEAT -> IDLE on accepted release.
REQ-017 press_pulse[i] SHALL be high for exactly one cycle on the cycle button_export[i] rises, then in REPEAT once every REPEAT_PERIOD cycles, the first repeat pulse occurring on the PRESSED->REPEAT transition.
REQ-018 hold[i] SHALL equal 1 exactly while channel i is in REPEAT.
REQ-019 An accepted release SHALL immediately cancel any pending repeat; no pulse on release.
REQ-020 Timing counters SHALL saturate and never wrap; width = clog2 of the largest parameter plus 1.
REQ-021 Channels SHALL be fully independent; simultaneous presses on several buttons SHALL yield simultaneous pulses.
REQ-022 Switches SHALL use debounce only: no FSM, pulse, or hold.

Reset
REQ-023 While reset_reset_n is low, all synchronizer flops, stable levels, counters and outputs SHALL be 0 and FSMs IDLE, asynchronously.
REQ-024 After reset release, a button already held SHALL be accepted as a new press after DEBOUNCE_CYCLES+2 cycles, producing a pulse.
REQ-025 Reset asserted mid-debounce or mid-repeat SHALL discard all progress; no pulse on the reset edge or release.

Structure
REQ-026 Package button_conditioner_pkg SHALL hold the FSM state enum (IDLE, PRESSED, REPEAT), channel counts (3 buttons, 3 switches), and the counter-width function.
REQ-027 One sub-module debounce_channel (synchronizer + counter + stable level, parameterized by DEBOUNCE_CYCLES) SHALL be instantiated 6 times; repeat FSMs live in the top.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-028 btn_raw[0] 1->0 held -> button_export[0] rises 6 cycles later, press_pulse[0] one cycle wide at the same cycle.
REQ-029 btn_raw[1] low for 3 cycles then high -> button_export and press_pulse stay 0.
REQ-030 btn_raw[2] held 40 cycles -> pulses at press+0, +10, +15, +20, ...; hold[2] high from press+10; release -> hold falls, no further pulses.
REQ-031 All three buttons pressed same cycle -> press_pulse = 3'b111 for one cycle.
REQ-032 sw_raw = 3'b101 steady -> switch_export = 3'b101 after 6 cycles; press_pulse unaffected.
REQ-033 Reset asserted during REPEAT -> all outputs 0 asynchronously; button held across release -> single new pulse 6 cycles after release.
